wb_grf: RTL
===========

Name: wb_grf

Overview:
Write-back stage and general register file for the 5-stage MIPS core, sitting on the consumer side of the MEM/WB pipeline register.
- Takes the W-stage fields: write enable, mem-to-reg select, read data, ALU result, destination, pc, jal flag and load type.
- Forms the final write data, including load byte/half extension and the jal link value, and commits it to 32x32 GPRs.
- Serves the two D-stage read ports and exposes the W-stage write data for the forwarding mux.
- Counts retired instructions.

Parameters:
LINK_OFFSET, 8, value added to pc_W to form the jal link address.
COUNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all GPRs and the counter.
valid_W  input  1  W stage holds a real instruction; 0 means a bubble.
RegWrite_W  input  1  instruction writes a GPR.
MemtoReg_W  input  1  1 selects load data, 0 selects ALUOut_W.
jal_W  input  1  1 selects pc_W+LINK_OFFSET; overrides MemtoReg_W.
MemType_W  input  3  load type: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as lw.
ReadData_W  input  32  aligned word read from DM.
ALUOut_W  input  32  ALU result; bits [1:0] give the load byte offset.
WriteReg_W  input  5  destination GPR.
pc_W  input  32  pc of the W-stage instruction.
A1_D  input  5  read address, port 1.
A2_D  input  5  read address, port 2.
RD1_D  output  32  read data, port 1 (combinational).
RD2_D  output  32  read data, port 2 (combinational).
WD_W  output  32  final write data (combinational), used for forwarding.
WE_W  output  1  effective write enable: valid_W & RegWrite_W & (WriteReg_W != 0).
retire_count  output  COUNT_W  number of retired valid instructions.

Behaviour:
- Reset: asynchronous and active-high, as already decided. On assert, GPR[0..31] and retire_count go to 0 immediately, so RD1_D/RD2_D read 0.
- While reset is high, writes and counting are suppressed.
- Deassert is sampled at the next rising edge.
- Write-data select, priority order:
  - jal_W: WD_W = pc_W + LINK_OFFSET, mod 2^32.
  - MemtoReg_W: WD_W = extended load data.
  - otherwise: WD_W = ALUOut_W.
- Load extension, with off = ALUOut_W[1:0]:
  - lb/lbu: byte ReadData_W[8*off+7 : 8*off], sign- or zero-extended.
  - lh/lhu: half ReadData_W[16*ALUOut_W[1]+15 : 16*ALUOut_W[1]], sign- or zero-extended; ALUOut_W[0] is ignored (alignment is checked upstream).
  - lw: the word unchanged.
- Commit: on the rising edge with WE_W=1, GPR[WriteReg_W] <= WD_W.
  - Writes to $0 are dropped; GPR[0] always reads 0.
  - Write latency is 1 cycle; without the bypass, the new value is visible on read ports the cycle after the edge.
- Read ports are combinational: address 0 returns 0, otherwise the GPR content. Both ports may read the same register.
- Counter: on the rising edge with valid_W=1, retire_count increments by 1, independent of RegWrite_W. It wraps from all-ones to 0 silently.
- Bubbles (valid_W=0) change no state.
- jal_W=1 with MemtoReg_W=1: jal wins.
- X on inputs while valid_W=0 must not propagate into state.

Optional Feature:
Macro GRF_BYPASS_EN.
- Defined: a read port whose address equals WriteReg_W while WE_W=1 returns WD_W in the same cycle (internal write-to-read bypass). Address 0 still returns 0.
- Undefined: read ports return stored GPR content only, and the hazard unit forwards from W.

Decomposition:
- Shared package mips_pkg: MemType encodings (MT_LW..MT_LHU), LINK_OFFSET default, REG_ZERO=5'd0.
- One sub-module: load_ext. Purely combinational; inputs ReadData_W, off, MemType_W; output the extended 32-bit value. Instantiated once.

Test Plan:
- Reset, then read all 32 addresses: all 0. Assert reset mid-run after writing GPR[5]=32'h1234: GPR[5] reads 0 before the next edge; retire_count=0.
- valid=1, RegWrite=1, MemtoReg=0, WriteReg=8, ALUOut=32'hDEADBEEF; next cycle A1=8 -> RD1=32'hDEADBEEF. Same with WriteReg=0 -> A1=0 reads 0.
- Loads with ReadData=32'h80FF7F01:
  - lb off=2 -> 32'hFFFFFFFF
  - lbu off=3 -> 32'h00000080
  - lh ALUOut[1]=1 -> 32'hFFFF80FF
  - lhu ALUOut[1]=0 -> 32'h00007F01
  - lb off=0 -> 32'h00000001
- jal_W=1, MemtoReg_W=1, pc_W=32'h00003010, WriteReg=31 -> GPR[31]=32'h00003018. pc_W=32'hFFFFFFFC -> 32'h00000004 (wrap).
- With GRF_BYPASS_EN: same-cycle write to GPR[9] with WD=7 and A2=9 -> RD2=7 in that cycle. Without the macro -> RD2 shows the old value until the edge.
- 5 valid instructions plus 3 bubbles -> retire_count=5. Preload the counter near all-ones via forced state, one more retire -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS write-back stage: load type encodings,
// default jal link offset and the hard-wired zero register index.
package mips_pkg;

  typedef enum logic [2:0] {
    MT_LW  = 3'd0,
    MT_LB  = 3'd1,
    MT_LBU = 3'd2,
    MT_LH  = 3'd3,
    MT_LHU = 3'd4
  } mem_type_e;

  localparam logic [31:0] LINK_OFFSET_DFLT = 32'd8;
  localparam logic [4:0]  REG_ZERO         = 5'd0;

endpackage

// File: rtl/load_ext.sv
// Load data extraction and extension for lb/lbu/lh/lhu/lw.
// Encodings 5-7 fall through to the plain word.
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0] ReadData_W,
  input  logic [1:0]  off,
  input  logic [2:0]  MemType_W,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // pick the addressed byte and half; off[0] is ignored for halves
  always_comb begin
    byte_sel = ReadData_W[7:0];
    case (off)
      2'd0: byte_sel = ReadData_W[7:0];
      2'd1: byte_sel = ReadData_W[15:8];
      2'd2: byte_sel = ReadData_W[23:16];
      2'd3: byte_sel = ReadData_W[31:24];
      default: byte_sel = ReadData_W[7:0];
    endcase
    half_sel = off[1] ? ReadData_W[31:16] : ReadData_W[15:0];
  end

  // sign or zero extend according to the load type
  always_comb begin
    ext_data = ReadData_W;
    case (MemType_W)
      MT_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      MT_LBU:  ext_data = {24'd0, byte_sel};
      MT_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      MT_LHU:  ext_data = {16'd0, half_sel};
      default: ext_data = ReadData_W;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage and 32x32 general register file.
// Optional macro GRF_BYPASS_EN: when defined, a read port addressing the
// register being written this cycle returns WD_W directly; otherwise read
// ports show stored content only and forwarding is left to the hazard unit.
module wb_grf
  import mips_pkg::*;
#(
  parameter logic [31:0] LINK_OFFSET = LINK_OFFSET_DFLT,
  parameter int          COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_W,
  input  logic               RegWrite_W,
  input  logic               MemtoReg_W,
  input  logic               jal_W,
  input  logic [2:0]         MemType_W,
  input  logic [31:0]        ReadData_W,
  input  logic [31:0]        ALUOut_W,
  input  logic [4:0]         WriteReg_W,
  input  logic [31:0]        pc_W,
  input  logic [4:0]         A1_D,
  input  logic [4:0]         A2_D,
  output logic [31:0]        RD1_D,
  output logic [31:0]        RD2_D,
  output logic [31:0]        WD_W,
  output logic               WE_W,
  output logic [COUNT_W-1:0] retire_count
);

  logic [31:0] gpr [32];
  logic [31:0] load_data;

  load_ext u_load_ext (
    .ReadData_W (ReadData_W),
    .off        (ALUOut_W[1:0]),
    .MemType_W  (MemType_W),
    .ext_data   (load_data)
  );

  // gating with valid_W first keeps X on bubble fields out of the write enable
  assign WE_W = valid_W & RegWrite_W & (WriteReg_W != REG_ZERO);

  // write-data select: jal link beats load data beats ALU result
  always_comb begin
    WD_W = ALUOut_W;
    if (jal_W)
      WD_W = pc_W + LINK_OFFSET;
    else if (MemtoReg_W)
      WD_W = load_data;
  end

  // register commit; entry 0 is cleared and never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        gpr[i] <= '0;
    end else if (WE_W) begin
      gpr[WriteReg_W] <= WD_W;
    end
  end

  // retired-instruction counter, wraps silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retire_count <= '0;
    else if (valid_W)
      retire_count <= retire_count + COUNT_W'(1);
  end

  // read port 1
  always_comb begin
    RD1_D = (A1_D == REG_ZERO) ? 32'd0 : gpr[A1_D];
`ifdef GRF_BYPASS_EN
    if (WE_W && (A1_D == WriteReg_W))
      RD1_D = WD_W;
`endif
  end

  // read port 2
  always_comb begin
    RD2_D = (A2_D == REG_ZERO) ? 32'd0 : gpr[A2_D];
`ifdef GRF_BYPASS_EN
    if (WE_W && (A2_D == WriteReg_W))
      RD2_D = WD_W;
`endif
  end

endmodule
